// File: rtl/ring_osc_meter.sv
// Ring-oscillator frequency meter: counts synchronized rising edges per channel
// over a programmable gate window and exposes per-channel results by channel select.
module ring_osc_meter #(
  parameter int unsigned N_OSC  = 7,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned GATE_W = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [N_OSC-1:0]  osc_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  input  logic [2:0]        sel,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count_out,
  output logic [CNT_W-1:0]  count_gray,
  output logic [N_OSC-1:0]  overflow
);

  localparam int unsigned GCNT_W = GATE_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEASURE, S_DONE} state_t;

  state_t              r_state;
  logic [N_OSC-1:0]    r_s1, r_s2, r_s3;
  logic [GCNT_W-1:0]   r_gate;
  logic [CNT_W-1:0]    r_cnt    [N_OSC];
  logic [CNT_W-1:0]    r_result [N_OSC];
  logic [N_OSC-1:0]    r_ovf_work;
  logic [N_OSC-1:0]    r_ovf;
  logic                r_busy;
  logic                r_done;
  logic [CNT_W-1:0]    r_count_out;
  logic [CNT_W-1:0]    r_count_gray;

  logic [N_OSC-1:0]    w_edge;
  logic [CNT_W-1:0]    w_sel_cnt;
  logic [CNT_W-1:0]    w_sel_res;
  logic [CNT_W-1:0]    w_next_out;

  assign w_edge = r_s2 & ~r_s3;

  // Two-flop synchronizer plus history flop for rising-edge detection
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= osc_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  always_comb begin
    w_sel_cnt = '0;
    w_sel_res = '0;
    for (int unsigned i = 0; i < N_OSC; i++) begin
      if (3'(i) == sel) begin
        w_sel_cnt = r_cnt[i];
        w_sel_res = r_result[i];
      end
    end
  end

  // During DONE the results are being loaded, so read the counters directly
  // to make new results visible on the output the cycle after done.
  assign w_next_out = (r_state == S_DONE) ? w_sel_cnt : w_sel_res;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state      <= S_IDLE;
      r_gate       <= '0;
      r_ovf_work   <= '0;
      r_ovf        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_count_out  <= '0;
      r_count_gray <= '0;
      for (int unsigned i = 0; i < N_OSC; i++) begin
        r_cnt[i]    <= '0;
        r_result[i] <= '0;
      end
    end else begin
      r_done       <= 1'b0;
      r_count_out  <= w_next_out;
      r_count_gray <= w_next_out ^ (w_next_out >> 1);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_gate  <= (gate_len == '0) ? {1'b1, {GATE_W{1'b0}}} : {1'b0, gate_len};
            r_state <= S_ARM;
            r_busy  <= 1'b1;
          end
        end
        S_ARM: begin
          for (int unsigned i = 0; i < N_OSC; i++) r_cnt[i] <= '0;
          r_ovf_work <= '0;
          r_state    <= S_MEASURE;
        end
        S_MEASURE: begin
          for (int unsigned i = 0; i < N_OSC; i++) begin
            if (w_edge[i]) begin
              if (r_cnt[i] == CNT_MAX) r_ovf_work[i] <= 1'b1;
              else                     r_cnt[i]      <= r_cnt[i] + CNT_W'(1);
            end
          end
          r_gate <= r_gate - GCNT_W'(1);
          if (r_gate == GCNT_W'(1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          for (int unsigned i = 0; i < N_OSC; i++) r_result[i] <= r_cnt[i];
          r_ovf   <= r_ovf_work;
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign count_out  = r_count_out;
  assign count_gray = r_count_gray;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_ring_osc_meter.sv
// Directed bench for ring_osc_meter: window timing, per-channel counts,
// Gray readout, saturation, start-ignore, mid-window reset and 2^GATE_W window.
module tb_ring_osc_meter;
  localparam int unsigned N_OSC  = 7;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned GATE_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic [N_OSC-1:0]  osc = '0;
  logic              start = 1'b0;
  logic [GATE_W-1:0] gate_len = '0;
  logic [2:0]        sel = '0;
  logic              busy, done;
  logic [CNT_W-1:0]  count_out, count_gray;
  logic [N_OSC-1:0]  overflow;

  logic              start8 = 1'b0;
  logic [GATE_W-1:0] gate_len8 = '0;
  logic              busy8, done8;
  logic [7:0]        count_out8, count_gray8;
  logic [N_OSC-1:0]  overflow8;

  ring_osc_meter #(.N_OSC(N_OSC), .CNT_W(CNT_W), .GATE_W(GATE_W)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .osc_in(osc), .start(start), .gate_len(gate_len),
    .sel(sel), .busy(busy), .done(done), .count_out(count_out), .count_gray(count_gray),
    .overflow(overflow));

  ring_osc_meter #(.N_OSC(N_OSC), .CNT_W(8), .GATE_W(GATE_W)) dut8 (
    .wb_clk_i(clk), .wb_rst_i(rst), .osc_in(osc), .start(start8), .gate_len(gate_len8),
    .sel(sel), .busy(busy8), .done(done8), .count_out(count_out8), .count_gray(count_gray8),
    .overflow(overflow8));

  // Oscillator model: half-period in clk cycles per channel, 0 holds low
  int half [N_OSC];
  int ocnt [N_OSC];
  always @(negedge clk) begin
    for (int i = 0; i < N_OSC; i++) begin
      if (half[i] == 0) begin
        osc[i] = 1'b0;
        ocnt[i] = 0;
      end else if (ocnt[i] + 1 >= half[i]) begin
        osc[i] = ~osc[i];
        ocnt[i] = 0;
      end else begin
        ocnt[i] = ocnt[i] + 1;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic set_half(input int h0, input int h1, input int h2, input int h3,
                          input int h4, input int h5, input int h6);
    half[0] = h0; half[1] = h1; half[2] = h2; half[3] = h3;
    half[4] = h4; half[5] = h5; half[6] = h6;
  endtask

  // Runs one window; leaves the time at the sample where busy has just dropped
  task automatic measure(input int gl, input int n, input int restart_at, input string tag);
    int  busy_cnt = 0;
    int  done_cnt = 0;
    int  done_at  = -1;
    bit  ended    = 1'b0;
    @(negedge clk);
    start = 1'b1;
    gate_len = GATE_W'(gl);
    @(negedge clk);
    for (int i = 1; i <= n + 10 && !ended; i++) begin
      if (i > 1) @(negedge clk);
      if (restart_at == i) begin
        start = 1'b1;
        gate_len = 16'd5;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = i;
      end
      if (!busy) ended = 1'b1;
    end
    start = 1'b0;
    check({tag, " window_ended"}, 32'(ended), 32'd1);
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(n + 2));
    check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, " done_cycle"}, 32'(done_at), 32'(n + 2));
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] exp_bin;
    logic [15:0] exp_gray;
  } vec_t;
  vec_t vecs [8];

  initial begin
    int done_seen;
    bit got_done;
    for (int i = 0; i < N_OSC; i++) begin
      half[i] = 0;
      ocnt[i] = 0;
    end
    vecs[0] = '{3'd0, 16'd10, 16'h000F};
    vecs[1] = '{3'd1, 16'd25, 16'h0015};
    vecs[2] = '{3'd2, 16'd5,  16'h0007};
    vecs[3] = '{3'd3, 16'd0,  16'h0000};
    vecs[4] = '{3'd4, 16'd50, 16'h002B};
    vecs[5] = '{3'd5, 16'd0,  16'h0000};
    vecs[6] = '{3'd7, 16'd0,  16'h0000};
    vecs[7] = '{3'd0, 16'd10, 16'h000F};

    repeat (3) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst count_out", 32'(count_out), 32'd0);
    check("rst count_gray", 32'(count_gray), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    // Mixed-rate measurement, then table-driven readback
    set_half(5, 2, 10, 0, 1, 0, 0);
    repeat (30) @(negedge clk);
    measure(100, 100, 0, "basic");
    check("basic count_out", 32'(count_out), 32'd10);
    check("basic count_gray", 32'(count_gray), 32'h0F);
    check("basic overflow", 32'(overflow), 32'd0);
    for (int v = 0; v < 8; v++) begin
      sel = vecs[v].sel;
      @(negedge clk);
      check($sformatf("vec%0d bin", v), 32'(count_out), 32'(vecs[v].exp_bin));
      check($sformatf("vec%0d gray", v), 32'(count_gray), 32'(vecs[v].exp_gray));
    end

    // start during MEASURE must not alter the window
    measure(100, 100, 20, "restart");
    check("restart count_out", 32'(count_out), 32'd10);

    // Reset mid-window
    @(negedge clk);
    start = 1'b1;
    gate_len = 16'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    check("midrst busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst count_out", 32'(count_out), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("midrst no_done", 32'(done_seen), 32'd0);
    repeat (10) @(negedge clk);
    measure(100, 100, 0, "after_rst");
    check("after_rst count_out", 32'(count_out), 32'd10);

    // Saturation on an 8-bit instance
    set_half(0, 0, 0, 2, 0, 0, 0);
    sel = 3'd3;
    repeat (20) @(negedge clk);
    start8 = 1'b1;
    gate_len8 = 16'd2000;
    @(negedge clk);
    start8 = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 2100 && !got_done; i++) begin
      @(negedge clk);
      if (done8) got_done = 1'b1;
    end
    check("sat done_seen", 32'(got_done), 32'd1);
    @(negedge clk);
    check("sat count_out", 32'(count_out8), 32'd255);
    check("sat count_gray", 32'(count_gray8), 32'd128);
    check("sat overflow", 32'(overflow8), 32'b0001000);

    // Zero gate length = 2^GATE_W window
    set_half(0, 0, 0, 0, 0, 0, 0);
    sel = 3'd0;
    repeat (20) @(negedge clk);
    measure(0, 65536, 0, "gate0");
    check("gate0 count_out", 32'(count_out), 32'd0);
    check("gate0 overflow", 32'(overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ring_osc_meter.md
# ring_osc_meter

Measures the frequencies of the seven free-running ring-oscillator outputs (periods of 3, 5, 7, 11, 13, 17 and 19 inverter stages) in the system clock domain. Each oscillator input passes through a synchronizer. Rising edges are counted over a programmable gate window of system-clock cycles. Results are held in per-channel registers, which are read back through a channel select as binary and as Gray code. The block sits between the oscillator bank and the Wishbone-facing register logic of the user project.

## Interface

Parameters:
- N_OSC, 7, number of oscillator channels
- CNT_W, 16, width of each edge counter and result register
- GATE_W, 16, width of the gate-length input

Ports:
- wb_clk_i  input  1  system clock; the only clock in the block
- wb_rst_i  input  1  synchronous reset, active-high
- osc_in  input  N_OSC  raw oscillator outputs, asynchronous to wb_clk_i; bit 0 = 3-stage ring … bit 6 = 19-stage ring
- start  input  1  request a measurement; sampled only in IDLE
- gate_len  input  GATE_W  window length in wb_clk_i cycles; sampled with start; 0 means 2^GATE_W
- sel  input  3  result channel select; values ≥ N_OSC read as 0
- busy  output  1  high while a measurement is in progress (ARM, MEASURE, DONE)
- done  output  1  one-cycle pulse when results are updated
- count_out  output  CNT_W  result[sel], binary
- count_gray  output  CNT_W  result[sel] in Gray code: bin ^ (bin >> 1)
- overflow  output  N_OSC  per-channel saturation flag from the last measurement

## Operation

- Per channel, osc_in passes through two synchronizer flops, s1 and s2, then a history flop s3. The edge pulse is s2 & ~s3.
- The block detects only edges with osc high and low periods of at least 1 wb_clk_i cycle each. Faster rings alias, and that is accepted behaviour.
- FSM states:
  - IDLE: if start=1, capture gate_len into the gate counter (0 loads 2^GATE_W) → ARM.
  - ARM: clear all edge counters and working overflow bits → MEASURE.
  - MEASURE: each cycle, every channel with an edge pulse increments its counter. The gate counter decrements each cycle. On the cycle the gate counter reads 1 → DONE.
  - DONE: copy counters into the result registers and working overflow bits into overflow; pulse done → IDLE.
- Saturation: a counter at 2^CNT_W−1 holds its value. An edge arriving at the saturated value sets that channel's working overflow bit.
- start is ignored outside IDLE; no queuing.
- Result registers and overflow hold their values until the next DONE or reset.
- count_out and count_gray are registered: they reflect sel and the result registers as of the previous cycle.

## Timing

- Reset: state IDLE, busy=0, done=0, count_out=0, count_gray=0, overflow=0, and all counters, result registers and synchronizer flops cleared.
- Start sequence, with start sampled high in IDLE at cycle T:
  - ARM at T+1.
  - MEASURE for exactly N cycles, T+2 … T+N+1, where N = gate_len (or 2^GATE_W if gate_len is 0).
  - DONE at T+N+2.
- busy is high during cycles T+1 … T+N+2 and is low again at T+N+3.
- done is high only at T+N+2. The new results appear on count_out and count_gray at T+N+3 (registered output).
- The earliest next start is sampled at T+N+3.
- Edge latency from osc_in to the edge pulse is 2–3 cycles. Pulses present in the pipeline when MEASURE begins are counted. Pulses arriving after the last MEASURE cycle are dropped.
- A sel change at cycle t updates count_out and count_gray at t+1.
- wb_rst_i asserted at any cycle, including mid-MEASURE or during DONE:
  - The next state is IDLE with all reset values, and done is not pulsed.
  - Reset takes priority over start in the same cycle.

## Test plan

- osc_in[0] toggles with period 10 cycles, gate_len=100, sel=0 → done after 102 cycles from start; count_out=10±1; overflow=0.
- Same stimulus with the count landing at 10 → count_gray=0x000F. Then sel=7 → count_out=0 and count_gray=0 on the next cycle.
- CNT_W=8, osc_in[3] period 4, gate_len=2000 → result[3]=255, overflow[3]=1, all other overflow bits 0.
- start re-asserted during MEASURE, with gate_len changed to 5 → ignored; the window stays at its original length and exactly one done pulse occurs.
- wb_rst_i pulsed at MEASURE cycle 50 of a 100-cycle window → busy=0 and count_out=0 the next cycle; no done pulse; a fresh start then measures normally.
- gate_len=0, GATE_W=16, all osc_in held at 0 → busy high for 65538 cycles, then done=1; all results 0.
